float_to_int: RTL and testbench



---
 rtl/float_to_int.sv | 140 ++++++++++++++
 tb/tb_float_to_int.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero; latency 3 edges (special) or 35-e (normal).
// One operand in flight; output_z_stb/output_z are held while output_z_ack is low, input_a_ack low while busy.
module float_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        CONVERT = 3'd3,
        PUT_Z   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_ack;
    logic               r_stb;
    logic [31:0]        r_out;
    logic [31:0]        r_a;
    logic [31:0]        r_m;
    logic signed [9:0]  r_e;
    logic               r_s;
    logic [31:0]        r_z;

    logic               w_ack_nxt;
    logic               w_stb_nxt;
    logic [31:0]        w_out_nxt;
    logic [31:0]        w_a_nxt;
    logic [31:0]        w_m_nxt;
    logic signed [9:0]  w_e_nxt;
    logic               w_s_nxt;
    logic [31:0]        w_z_nxt;

    logic               w_accept;
    logic               w_deliver;
    logic               w_sat;
    logic               w_zero;

    assign w_accept  = r_ack && input_a_stb;
    assign w_deliver = r_stb && output_z_ack;

    // Saturation is checked before underflow so Inf/NaN never fall through to zero.
    assign w_sat  = (r_a[30:23] == 8'hFF) || (r_e >= 10'sd31);
    assign w_zero = (r_a[30:23] == 8'h00) || (r_e < 10'sd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GET_A;
            r_ack   <= 1'b0;
            r_stb   <= 1'b0;
            r_out   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_stb   <= w_stb_nxt;
            r_out   <= w_out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_a <= w_a_nxt;
        r_m <= w_m_nxt;
        r_e <= w_e_nxt;
        r_s <= w_s_nxt;
        r_z <= w_z_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GET_A:   if (w_accept) w_state_nxt = UNPACK;
            UNPACK:  w_state_nxt = SPECIAL;
            SPECIAL: w_state_nxt = (w_sat || w_zero) ? PUT_Z : CONVERT;
            CONVERT: if (r_e >= 10'sd31) w_state_nxt = PUT_Z;
            PUT_Z:   if (w_deliver) w_state_nxt = GET_A;
            default: w_state_nxt = GET_A;
        endcase
    end

    always_comb begin
        w_ack_nxt = r_ack;
        w_stb_nxt = r_stb;
        w_out_nxt = r_out;
        w_a_nxt   = r_a;
        w_m_nxt   = r_m;
        w_e_nxt   = r_e;
        w_s_nxt   = r_s;
        w_z_nxt   = r_z;
        case (r_state)
            GET_A: begin
                w_ack_nxt = 1'b1;
                if (w_accept) begin
                    w_a_nxt   = input_a;
                    w_ack_nxt = 1'b0;
                end
            end
            UNPACK: begin
                w_m_nxt = {1'b1, r_a[22:0], 8'h00};
                w_e_nxt = $signed({2'b00, r_a[30:23]}) - 10'sd127;
                w_s_nxt = r_a[31];
            end
            SPECIAL: begin
                if (w_sat)       w_z_nxt = 32'h8000_0000;
                else if (w_zero) w_z_nxt = 32'd0;
            end
            CONVERT: begin
                // m carries the hidden one at bit 31, so 31-e right shifts leave the integer part.
                if (r_e < 10'sd31) begin
                    w_m_nxt = r_m >> 1;
                    w_e_nxt = r_e + 10'sd1;
                end else begin
                    w_z_nxt = r_s ? (~r_m + 32'd1) : r_m;
                end
            end
            PUT_Z: begin
                w_stb_nxt = 1'b1;
                w_out_nxt = r_z;
                if (w_deliver) w_stb_nxt = 1'b0;
            end
            default: begin
                w_ack_nxt = 1'b0;
                w_stb_nxt = 1'b0;
            end
        endcase
    end

    assign input_a_ack  = r_ack;
    assign output_z_stb = r_stb;
    assign output_z     = r_out;

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int: directed literal cases plus randomized operands checked against an arithmetic model.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = 32'd0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq[$];

    float_to_int dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Reference: value = 1.frac * 2^e, integer part taken by plain shifting.
    function automatic logic [31:0] model_z(input logic [31:0] a);
        int          ex;
        logic [31:0] mag;
        logic [31:0] sig;
        ex = int'(a[30:23]) - 127;
        if (a[30:23] == 8'hFF || ex >= 31) return 32'h8000_0000;
        if (a[30:23] == 8'h00 || ex < 0)   return 32'd0;
        sig = {8'h00, 1'b1, a[22:0]};
        if (ex >= 23) mag = sig << (ex - 23);
        else          mag = sig >> (23 - ex);
        return a[31] ? (32'd0 - mag) : mag;
    endfunction

    function automatic int model_lat(input logic [31:0] a);
        int ex;
        ex = int'(a[30:23]) - 127;
        if (a[30:23] == 8'hFF || a[30:23] == 8'h00 || ex >= 31 || ex < 0) return 3;
        return 35 - ex;
    endfunction

    // Stream checker: every cycle the DUT offers a result it must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst && output_z_stb) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_stb: got z=0x%08h want no output", output_z);
            end else begin
                check("stream_z", output_z, expq[0]);
                if (output_z_ack) void'(expq.pop_front());
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input int hold, input bit use_lit,
                         input logic [31:0] lit_z, input int lit_lat, input string name);
        int          lat;
        bit          ok;
        bit          busy_ack;
        logic [31:0] zs;
        input_a      = a;
        input_a_stb  = 1'b1;
        output_z_ack = (hold == 0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (input_a_ack) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_accept: got no input_a_ack want ack within 100 cycles", name);
            input_a_stb = 1'b0;
            return;
        end
        expq.push_back(model_z(a));
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        input_a     = $urandom;
        ok = 1'b0;
        lat = 0;
        busy_ack = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (input_a_ack) busy_ack = 1'b1;
            @(posedge clk);
            #1;
            if (output_z_stb) begin lat = n; ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no output_z_stb want stb within 60 cycles", name);
            expq.delete();
            return;
        end
        check({name, "_busy_ack"}, 32'(busy_ack), 32'd0);
        check({name, "_lat"}, 32'(lat), use_lit ? 32'(lit_lat) : 32'(model_lat(a)));
        if (use_lit) check({name, "_z"}, output_z, lit_z);
        zs = output_z;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_stb"}, 32'(output_z_stb), 32'd1);
            check({name, "_hold_z"}, output_z, zs);
            check({name, "_hold_ack"}, 32'(input_a_ack), 32'd0);
        end
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_stb_drop"}, 32'(output_z_stb), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_ack_back"}, 32'(input_a_ack), 32'd1);
    endtask

    logic [31:0] d_a   [12] = '{32'h3F80_0000, 32'h4E80_0000, 32'hC020_0000, 32'h3F40_0000,
                                32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h4F00_0000,
                                32'hCF00_0000, 32'h0000_0001, 32'h4B00_0001, 32'hC2F6_0000};
    logic [31:0] d_z   [12] = '{32'h0000_0001, 32'h4000_0000, 32'hFFFF_FFFE, 32'h0000_0000,
                                32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                32'h8000_0000, 32'h0000_0000, 32'h0080_0001, 32'hFFFF_FF85};
    int          d_lat [12] = '{35, 5, 34, 3, 3, 3, 3, 3, 3, 3, 12, 29};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        int          rh;

        // Pin the model against hand-computed values.
        check("model_one",  model_z(32'h3F80_0000), 32'h0000_0001);
        check("model_neg",  model_z(32'hC020_0000), 32'hFFFF_FFFE);
        check("model_prec", model_z(32'h4B00_0001), 32'h0080_0001);
        check("model_lat",  32'(model_lat(32'h3F80_0000)), 32'd35);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(input_a_ack),  32'd0);
        check("rst_stb", 32'(output_z_stb), 32'd0);
        check("rst_z",   output_z,          32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ack_after_rst", 32'(input_a_ack), 32'd1);

        for (int i = 0; i < 12; i++)
            do_op(d_a[i], 0, 1'b1, d_z[i], d_lat[i], $sformatf("dir%0d", i));

        // Backpressure: result held for 10 cycles before downstream takes it.
        do_op(32'h4120_0000, 10, 1'b1, 32'h0000_000A, 32, "bp");

        // Reset while the denormaliser is still shifting.
        input_a     = 32'h3F80_0000;
        input_a_stb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (input_a_ack) break;
        end
        expq.push_back(model_z(32'h3F80_0000));
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        check("midrst_stb", 32'(output_z_stb), 32'd0);
        check("midrst_ack", 32'(input_a_ack),  32'd0);
        check("midrst_z",   output_z,          32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ack_back", 32'(input_a_ack), 32'd1);
        do_op(32'h4040_0000, 0, 1'b1, 32'h0000_0003, 34, "after_rst");

        for (int i = 0; i < 250; i++) begin
            ra[31]    = 1'($urandom_range(0, 1));
            ra[22:0]  = 23'($urandom);
            case ($urandom_range(0, 9))
                0:       ra[30:23] = 8'h00;
                1:       ra[30:23] = 8'hFF;
                default: ra[30:23] = 8'($urandom_range(110, 165));
            endcase
            rh = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            do_op(ra, rh, 1'b0, 32'd0, 0, "rnd");
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
